// File: rtl/datapath_acc_scan.sv
// Purpose : accumulator datapath with a 4-op ALU, carry/zero flags and a full-scan chain over AC, C and Z.
// Latency : a functional load or scan shift is visible one edge later; OUT_REG=1 adds one more edge on OutBus/CarryF/ZeroF.
// Backpressure: none. The sequencer owns every control line, and the block accepts a new operation every cycle.
//
// Ports
//   clock    rising-edge clock (single domain)
//   reset    synchronous active-high reset; it wins over scan and load in the same cycle
//   ABus     external operand
//   SelB     B operand select: 1 = ABus, 0 = AC (feedback)
//   AluOp    00 PASS_B, 01 ADD, 10 SUB, 11 AND
//   LoadAC   capture the ALU result and flags
//   ScanEn   shift the scan chain; blocks the functional load
//   ScanIn   serial scan input, which feeds AC[0]
//   ScanOut  serial scan output, which is the Z register itself
//   OutBus   accumulator value, optionally registered
//   CarryF   carry / no-borrow flag, optionally registered
//   ZeroF    zero flag, optionally registered
module datapath_acc_scan #(
   parameter int WIDTH   = 4,
   parameter bit OUT_REG = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] ABus,
   input  logic             SelB,
   input  logic [1:0]       AluOp,
   input  logic             LoadAC,
   input  logic             ScanEn,
   input  logic             ScanIn,
   output logic             ScanOut,
   output logic [WIDTH-1:0] OutBus,
   output logic             CarryF,
   output logic             ZeroF
);

   typedef enum logic [1:0] {
      OpPass = 2'b00,
      OpAdd  = 2'b01,
      OpSub  = 2'b10,
      OpAnd  = 2'b11
   } aluOp_t;

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   aluOp_t           op;
   logic [WIDTH-1:0] acReg;
   logic             cReg;
   logic             zReg;
   logic [WIDTH-1:0] bBus;
   logic [WIDTH:0]   sumExt;
   logic [WIDTH-1:0] aluRes;
   logic             aluCarry;
   logic             aluZero;

   assign op   = aluOp_t'(AluOp);
   assign bBus = SelB ? ABus : acReg;

   // SUB is formed as AC + ~B + 1, so the carry out is the no-borrow flag:
   // it is 1 exactly when AC >= B. All four encodings are decoded, so no X
   // can reach the accumulator whichever AluOp value is presented.
   always_comb begin
      sumExt   = '0;
      aluRes   = '0;
      aluCarry = 1'b0;
      case (op)
         OpPass: begin
            aluRes = bBus;
         end
         OpAdd: begin
            sumExt   = {1'b0, acReg} + {1'b0, bBus};
            aluRes   = sumExt[WIDTH-1:0];
            aluCarry = sumExt[WIDTH];
         end
         OpSub: begin
            sumExt   = {1'b0, acReg} + {1'b0, ~bBus} + ONE;
            aluRes   = sumExt[WIDTH-1:0];
            aluCarry = sumExt[WIDTH];
         end
         OpAnd: begin
            aluRes = acReg & bBus;
         end
         default: begin
            aluRes   = '0;
            aluCarry = 1'b0;
         end
      endcase
   end

   assign aluZero = (aluRes == '0);

   // The state registers double as the scan chain:
   // ScanIn -> AC[0] .. AC[WIDTH-1] -> C -> Z -> ScanOut.
   // While a shift is in progress the functional load is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         acReg <= '0;
         cReg  <= 1'b0;
         zReg  <= 1'b0;
      end else if (ScanEn) begin
         acReg <= {acReg[WIDTH-2:0], ScanIn};
         cReg  <= acReg[WIDTH-1];
         zReg  <= cReg;
      end else if (LoadAC) begin
         acReg <= aluRes;
         cReg  <= aluCarry;
         zReg  <= aluZero;
      end
   end

   // Z is the last cell of the chain, so it drives ScanOut directly in every mode.
   assign ScanOut = zReg;

   generate
      if (OUT_REG) begin : gOutReg
         // The output stage sits outside the scan chain. It follows AC, C and Z
         // on every edge, including edges where the chain is shifting.
         logic [WIDTH-1:0] outAc;
         logic             outC;
         logic             outZ;

         always_ff @(posedge clock) begin
            if (reset) begin
               outAc <= '0;
               outC  <= 1'b0;
               outZ  <= 1'b0;
            end else begin
               outAc <= acReg;
               outC  <= cReg;
               outZ  <= zReg;
            end
         end

         assign OutBus = outAc;
         assign CarryF = outC;
         assign ZeroF  = outZ;
      end else begin : gOutDirect
         assign OutBus = acReg;
         assign CarryF = cReg;
         assign ZeroF  = zReg;
      end
   endgenerate

endmodule

// File: tb/tb_datapath_acc_scan.sv
// Purpose : self-checking bench for datapath_acc_scan. It drives directed and random stimulus into an OUT_REG=0 and an OUT_REG=1 instance.
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the stimulus is presented every cycle.
module tb_datapath_acc_scan;

   localparam int W = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic [W-1:0] ABus;
   logic         SelB;
   logic [1:0]   AluOp;
   logic         LoadAC;
   logic         ScanEn;
   logic         ScanIn;

   logic         ScanOut0, CarryF0, ZeroF0;
   logic [W-1:0] OutBus0;
   logic         ScanOut1, CarryF1, ZeroF1;
   logic [W-1:0] OutBus1;

   int errors = 0;
   int checks = 0;

   // Reference model state, kept as plain integers.
   int mAc, mC, mZ;
   // Expected values for the registered-output instance.
   int eAc1, eC1, eZ1;

   always #5 clock = ~clock;

   datapath_acc_scan #(.WIDTH(W), .OUT_REG(1'b0)) dut0 (
      .clock(clock), .reset(reset), .ABus(ABus), .SelB(SelB), .AluOp(AluOp),
      .LoadAC(LoadAC), .ScanEn(ScanEn), .ScanIn(ScanIn),
      .ScanOut(ScanOut0), .OutBus(OutBus0), .CarryF(CarryF0), .ZeroF(ZeroF0));

   datapath_acc_scan #(.WIDTH(W), .OUT_REG(1'b1)) dut1 (
      .clock(clock), .reset(reset), .ABus(ABus), .SelB(SelB), .AluOp(AluOp),
      .LoadAC(LoadAC), .ScanEn(ScanEn), .ScanIn(ScanIn),
      .ScanOut(ScanOut1), .OutBus(OutBus1), .CarryF(CarryF1), .ZeroF(ZeroF1));

   // Applies one rising edge. The model is updated from the current inputs,
   // and the registered-output expectation is taken from the pre-edge state.
   task automatic tick();
      int b, r, c;
      bit q[$];
      if (reset) begin
         eAc1 = 0; eC1 = 0; eZ1 = 0;
      end else begin
         eAc1 = mAc; eC1 = mC; eZ1 = mZ;
      end
      if (reset) begin
         mAc = 0; mC = 0; mZ = 0;
      end else if (ScanEn) begin
         // The chain is held as a list ordered from the ScanIn end to the
         // ScanOut end. A shift pushes ScanIn at the front and drops the last bit.
         for (int i = 0; i < W; i++) q.push_back(bit'((mAc >> i) & 1));
         q.push_back(bit'(mC));
         q.push_back(bit'(mZ));
         q.push_front(ScanIn);
         void'(q.pop_back());
         mAc = 0;
         for (int i = 0; i < W; i++) mAc += int'(q[i]) << i;
         mC = int'(q[W]);
         mZ = int'(q[W+1]);
      end else if (LoadAC) begin
         b = SelB ? int'(ABus) : mAc;
         c = 0;
         case (AluOp)
            2'b00: r = b;
            2'b01: begin r = (mAc + b) % (1 << W); c = (mAc + b >= (1 << W)) ? 1 : 0; end
            2'b10: begin r = (mAc - b + (1 << W)) % (1 << W); c = (mAc >= b) ? 1 : 0; end
            default: r = mAc & b;
         endcase
         mAc = r; mC = c; mZ = (r == 0) ? 1 : 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic setOp(input logic ld, input logic sel, input logic [1:0] op, input logic [W-1:0] a);
      LoadAC = ld; SelB = sel; AluOp = op; ABus = a;
   endtask

   task automatic test_reset();
      setOp(1'b1, 1'b1, 2'b00, 4'h9);
      tick();
      checks++; if (OutBus0 !== 4'h9) begin errors++; $display("FAIL preload9 OutBus got %h want 9", OutBus0); end
      // Reset is asserted while a load is also requested; reset must win.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (OutBus0 !== 4'h0) begin errors++; $display("FAIL reset_out OutBus got %h want 0", OutBus0); end
      checks++; if (CarryF0 !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", CarryF0); end
      checks++; if (ZeroF0 !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", ZeroF0); end
      checks++; if (ScanOut0 !== 1'b0) begin errors++; $display("FAIL reset_scanout got %b want 0", ScanOut0); end
      checks++; if (OutBus1 !== 4'h0) begin errors++; $display("FAIL reset_outreg OutBus1 got %h want 0", OutBus1); end
   endtask

   task automatic test_load_add();
      setOp(1'b1, 1'b1, 2'b00, 4'hF);
      tick();
      checks++; if (OutBus0 !== 4'hF) begin errors++; $display("FAIL pass_f OutBus got %h want f", OutBus0); end
      checks++; if (CarryF0 !== 1'b0 || ZeroF0 !== 1'b0) begin errors++; $display("FAIL pass_f_flags got C=%b Z=%b want 0 0", CarryF0, ZeroF0); end
      setOp(1'b1, 1'b1, 2'b01, 4'h6);
      tick();
      checks++; if (OutBus0 !== 4'h5) begin errors++; $display("FAIL add_wrap OutBus got %h want 5", OutBus0); end
      checks++; if (CarryF0 !== 1'b1 || ZeroF0 !== 1'b0) begin errors++; $display("FAIL add_wrap_flags got C=%b Z=%b want 1 0", CarryF0, ZeroF0); end
      setOp(1'b0, 1'b1, 2'b01, 4'h3);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (OutBus0 !== 4'h5 || CarryF0 !== 1'b1) begin errors++; $display("FAIL hold%0d got %h C=%b want 5 C=1", i, OutBus0, CarryF0); end
      end
   endtask

   task automatic test_sub();
      setOp(1'b1, 1'b1, 2'b10, 4'h5);
      tick();
      checks++; if (OutBus0 !== 4'h0 || CarryF0 !== 1'b1 || ZeroF0 !== 1'b1) begin errors++; $display("FAIL sub_equal got %h C=%b Z=%b want 0 1 1", OutBus0, CarryF0, ZeroF0); end
      setOp(1'b1, 1'b1, 2'b00, 4'h5);
      tick();
      setOp(1'b1, 1'b1, 2'b10, 4'h6);
      tick();
      checks++; if (OutBus0 !== 4'hF || CarryF0 !== 1'b0 || ZeroF0 !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h C=%b Z=%b want f 0 0", OutBus0, CarryF0, ZeroF0); end
   endtask

   task automatic test_feedback_and();
      setOp(1'b1, 1'b1, 2'b00, 4'h3);
      tick();
      setOp(1'b1, 1'b0, 2'b01, 4'hC);
      tick();
      checks++; if (OutBus0 !== 4'h6) begin errors++; $display("FAIL feedback_double got %h want 6", OutBus0); end
      setOp(1'b1, 1'b1, 2'b11, 4'hA);
      tick();
      checks++; if (OutBus0 !== 4'h2 || CarryF0 !== 1'b0 || ZeroF0 !== 1'b0) begin errors++; $display("FAIL and got %h C=%b Z=%b want 2 0 0", OutBus0, CarryF0, ZeroF0); end
   endtask

   task automatic test_scan();
      logic [5:0] bits;
      logic [5:0] prior;
      logic [2:0] bits2;
      bits  = 6'b101101;     // bits[5] is shifted first: 1,0,1,1,0,1
      // The state left by the previous test is AC=2, C=0, Z=0. It leaves the
      // chain in the order Z, C, AC3, AC2, AC1, AC0.
      prior = 6'b000010;
      setOp(1'b1, 1'b1, 2'b01, 4'hF);
      ScanEn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++; if (ScanOut0 !== prior[5-i]) begin errors++; $display("FAIL scan_unload%0d got %b want %b", i, ScanOut0, prior[5-i]); end
         ScanIn = bits[5-i];
         tick();
      end
      checks++; if (OutBus0 !== 4'b1101) begin errors++; $display("FAIL scan_ac got %b want 1101", OutBus0); end
      checks++; if (CarryF0 !== 1'b0 || ZeroF0 !== 1'b1 || ScanOut0 !== 1'b1) begin errors++; $display("FAIL scan_flags got C=%b Z=%b SO=%b want 0 1 1", CarryF0, ZeroF0, ScanOut0); end
      checks++; if (OutBus1 !== eAc1[W-1:0]) begin errors++; $display("FAIL scan_outreg got %h want %h", OutBus1, eAc1[W-1:0]); end
      bits2 = 3'b011;
      for (int i = 0; i < 3; i++) begin
         ScanIn = bits2[2-i];
         tick();
         checks++; if (ScanOut0 !== mZ[0] || OutBus0 !== mAc[W-1:0]) begin errors++; $display("FAIL scan2_step%0d got SO=%b AC=%h want %b %h", i, ScanOut0, OutBus0, mZ[0], mAc[W-1:0]); end
      end
      // Reset is asserted in the middle of the shift.
      reset = 1'b1;
      ScanIn = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (OutBus0 !== 4'h0 || CarryF0 !== 1'b0 || ZeroF0 !== 1'b0 || ScanOut0 !== 1'b0) begin errors++; $display("FAIL scan_reset got %h C=%b Z=%b SO=%b want all 0", OutBus0, CarryF0, ZeroF0, ScanOut0); end
      checks++; if (OutBus1 !== 4'h0) begin errors++; $display("FAIL scan_reset_outreg got %h want 0", OutBus1); end
      ScanEn = 1'b0;
   endtask

   task automatic test_outreg();
      setOp(1'b1, 1'b1, 2'b00, 4'hF);
      tick();
      checks++; if (OutBus0 !== 4'hF || OutBus1 !== 4'h0) begin errors++; $display("FAIL outreg_f got AC=%h OB1=%h want f 0", OutBus0, OutBus1); end
      setOp(1'b1, 1'b1, 2'b01, 4'h6);
      tick();
      checks++; if (OutBus0 !== 4'h5 || OutBus1 !== 4'hF) begin errors++; $display("FAIL outreg_5 got AC=%h OB1=%h want 5 f", OutBus0, OutBus1); end
      checks++; if (CarryF1 !== 1'b0) begin errors++; $display("FAIL outreg_c_lag got %b want 0", CarryF1); end
      setOp(1'b0, 1'b1, 2'b01, 4'h6);
      tick();
      checks++; if (OutBus1 !== 4'h5 || CarryF1 !== 1'b1 || ZeroF1 !== 1'b0) begin errors++; $display("FAIL outreg_hold got %h C=%b Z=%b want 5 1 0", OutBus1, CarryF1, ZeroF1); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (OutBus1 !== 4'h0 || CarryF1 !== 1'b0) begin errors++; $display("FAIL outreg_reset got %h C=%b want 0 0", OutBus1, CarryF1); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset  = ($urandom_range(0, 31) == 0);
         ScanEn = ($urandom_range(0, 5) == 0);
         LoadAC = ($urandom_range(0, 3) != 0);
         SelB   = 1'($urandom);
         AluOp  = 2'($urandom);
         ABus   = W'($urandom);
         ScanIn = 1'($urandom);
         tick();
         checks++; if (OutBus0 !== mAc[W-1:0] || CarryF0 !== mC[0] || ZeroF0 !== mZ[0]) begin errors++; $display("FAIL rand%0d_dut0 got %h C=%b Z=%b want %h %b %b", n, OutBus0, CarryF0, ZeroF0, mAc[W-1:0], mC[0], mZ[0]); end
         checks++; if (ScanOut0 !== mZ[0] || ScanOut1 !== mZ[0]) begin errors++; $display("FAIL rand%0d_scanout got %b/%b want %b", n, ScanOut0, ScanOut1, mZ[0]); end
         checks++; if (OutBus1 !== eAc1[W-1:0] || CarryF1 !== eC1[0] || ZeroF1 !== eZ1[0]) begin errors++; $display("FAIL rand%0d_dut1 got %h C=%b Z=%b want %h %b %b", n, OutBus1, CarryF1, ZeroF1, eAc1[W-1:0], eC1[0], eZ1[0]); end
      end
      reset = 1'b0; ScanEn = 1'b0; LoadAC = 1'b0;
   endtask

   initial begin
      mAc = 0; mC = 0; mZ = 0;
      eAc1 = 0; eC1 = 0; eZ1 = 0;
      reset = 1'b1; ABus = '0; SelB = 1'b0; AluOp = 2'b00;
      LoadAC = 1'b0; ScanEn = 1'b0; ScanIn = 1'b0;
      tick();
      reset = 1'b0;
      test_reset();
      test_load_add();
      test_sub();
      test_feedback_and();
      test_scan();
      test_outreg();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
